// File: rtl/alu_csr_if.sv
// ALU CSR handshake bundle between the FU-stage initiator and the ALU responder.
// Initiator drives operands, op and strobes; responder returns result and status.
interface alu_csr_if #(
  parameter int DBITS  = 32,
  parameter int OPBITS = 4
);
  logic [DBITS-1:0]  OP1;
  logic [DBITS-1:0]  OP2;
  logic [OPBITS-1:0] ALUOP;
  logic [2:0]        CSR_ALU_IN;
  logic [DBITS-1:0]  OP3;
  logic [2:0]        CSR_ALU_OUT;

  modport master (
    output OP1, OP2, ALUOP, CSR_ALU_IN,
    input  OP3, CSR_ALU_OUT
  );

  modport slave (
    input  OP1, OP2, ALUOP, CSR_ALU_IN,
    output OP3, CSR_ALU_OUT
  );
endinterface

// File: rtl/alu_csr_responder.sv
// Responder side of the FU-stage ALU CSR handshake with a fixed-latency ALU.
// Define ALU_MULDIV_EN to add MUL (10), MULHU (11) and DIVU (12).
module alu_csr_responder #(
  parameter int DBITS   = 32,
  parameter int OPBITS  = 4,
  parameter int LATENCY = 3
) (
  input  logic       clk,
  input  logic       reset,
  alu_csr_if.slave   bus
);

  localparam logic [2:0] S_OP1  = 3'd0;
  localparam logic [2:0] S_OP2  = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_RES  = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  localparam logic [3:0] LAT = 4'(LATENCY);
`ifdef ALU_MULDIV_EN
  localparam logic [3:0] LAT_MD = (LATENCY > 4) ? 4'(LATENCY) : 4'd4;
`endif

  logic [2:0]        state_q, state_d;
  logic [DBITS-1:0]  op1_q, op1_d;
  logic [DBITS-1:0]  op2_q, op2_d;
  logic [OPBITS-1:0] op_q, op_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DBITS-1:0]  op3_q, op3_d;
  logic [2:0]        out_q, out_d;
  logic [DBITS-1:0]  res;
  logic [4:0]        sh;
  logic [3:0]        lat_ld;

`ifdef ALU_MULDIV_EN
  logic [2*DBITS-1:0] prod;
`endif

  // Result of the latched operation, valid whenever op1/op2/op are latched
  always_comb begin
    res = '0;
    sh  = op2_q[4:0];
`ifdef ALU_MULDIV_EN
    prod = {{DBITS{1'b0}}, op1_q} * {{DBITS{1'b0}}, op2_q};
`endif
    case (op_q)
      OPBITS'(0):  res = op1_q + op2_q;
      OPBITS'(1):  res = op1_q - op2_q;
      OPBITS'(2):  res = op1_q & op2_q;
      OPBITS'(3):  res = op1_q | op2_q;
      OPBITS'(4):  res = op1_q ^ op2_q;
      OPBITS'(5):  res = op1_q << sh;
      OPBITS'(6):  res = op1_q >> sh;
      OPBITS'(7):  res = DBITS'($signed(op1_q) >>> sh);
      OPBITS'(8):  res = {{(DBITS-1){1'b0}},
                          $signed(op1_q) < $signed(op2_q)};
      OPBITS'(9):  res = {{(DBITS-1){1'b0}}, op1_q < op2_q};
`ifdef ALU_MULDIV_EN
      OPBITS'(10): res = prod[DBITS-1:0];
      OPBITS'(11): res = prod[2*DBITS-1:DBITS];
      OPBITS'(12): res = (op2_q == '0) ? '1 : op1_q / op2_q;
`endif
      default:     res = '0;
    endcase
  end

  // Latency to load at OP2 capture, longer for mul/div ops
  always_comb begin
    lat_ld = LAT;
`ifdef ALU_MULDIV_EN
    if (bus.ALUOP == OPBITS'(10) ||
        bus.ALUOP == OPBITS'(11) ||
        bus.ALUOP == OPBITS'(12))
      lat_ld = LAT_MD;
`endif
  end

  // Handshake FSM, operand capture and result write
  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    op3_d   = op3_q;
    case (state_q)
      S_OP1: begin
        if (bus.CSR_ALU_IN[1]) begin
          op1_d   = bus.OP1;
          state_d = S_OP2;
        end
      end
      S_OP2: begin
        if (bus.CSR_ALU_IN[2]) begin
          op2_d   = bus.OP2;
          op_d    = bus.ALUOP;
          cnt_d   = lat_ld;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          op3_d   = res;
          state_d = S_RES;
        end
      end
      S_RES: begin
        if (bus.CSR_ALU_IN[0])
          state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!bus.CSR_ALU_IN[0])
          state_d = S_OP1;
      end
      default: state_d = S_OP1;
    endcase
  end

  // Status flags registered from the next state
  always_comb begin
    out_d = 3'b000;
    case (state_d)
      S_OP1:  out_d = 3'b001;
      S_OP2:  out_d = 3'b010;
      S_RES:  out_d = 3'b100;
      S_HOLD: out_d = 3'b100;
      default: out_d = 3'b000;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_OP1;
      op1_q   <= '0;
      op2_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      op3_q   <= '0;
      out_q   <= 3'b001;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      op3_q   <= op3_d;
      out_q   <= out_d;
    end
  end

  assign bus.OP3         = op3_q;
  assign bus.CSR_ALU_OUT = out_q;

endmodule

// File: tb/tb_alu_csr_responder.sv
// Self-checking bench for alu_csr_responder: directed and random ops
// compared against an arithmetic reference model.
module tb_alu_csr_responder;

  localparam int L = 3;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  alu_csr_if #(.DBITS(32), .OPBITS(4)) bus ();

  alu_csr_responder #(
    .DBITS(32), .OPBITS(4), .LATENCY(L)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(
    input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [63:0] p;
    int unsigned s;
    s = int'(b[4:0]);
    p = {32'b0, a} * {32'b0, b};
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << s;
      4'd6: return a >> s;
      4'd7: return a[31] ? ((a >> s) | ~(32'hFFFF_FFFF >> s)) : (a >> s);
      4'd8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MULDIV_EN
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
`ifdef ALU_MULDIV_EN
    if (op >= 4'd10 && op <= 4'd12) return (L > 4) ? L : 4;
`endif
    return L;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input int hold_n,
                        input string tag);
    logic [31:0] exp;
    int n;
    exp = ref_alu(a, b, op);
    chk({tag, ":rdy1"}, 32'(bus.CSR_ALU_OUT), 32'h1);
    bus.OP1 = a;
    bus.CSR_ALU_IN = 3'b010;
    step();
    bus.CSR_ALU_IN = 3'b000;
    bus.OP1 = $urandom;
    chk({tag, ":rdy2"}, 32'(bus.CSR_ALU_OUT), 32'h2);
    bus.OP2 = b;
    bus.ALUOP = op;
    bus.CSR_ALU_IN = 3'b100;
    step();
    bus.CSR_ALU_IN = 3'b000;
    bus.OP2 = $urandom;
    bus.ALUOP = 4'($urandom);
    n = 0;
    while (n < 40) begin
      step();
      n++;
      if (bus.CSR_ALU_OUT[2]) break;
    end
    chk({tag, ":lat"}, 32'(n), 32'(exp_lat(op)));
    chk({tag, ":res"}, bus.OP3, exp);
    chk({tag, ":valid"}, 32'(bus.CSR_ALU_OUT), 32'h4);
    bus.CSR_ALU_IN = 3'b001;
    step();
    for (int i = 0; i < hold_n; i++) begin
      bus.CSR_ALU_IN = {1'b0, i[0], 1'b1};
      step();
      chk({tag, ":hold_out"}, 32'(bus.CSR_ALU_OUT), 32'h4);
      chk({tag, ":hold_op3"}, bus.OP3, exp);
    end
    bus.CSR_ALU_IN = 3'b000;
    step();
    chk({tag, ":rel"}, 32'(bus.CSR_ALU_OUT), 32'h1);
    chk({tag, ":keep"}, bus.OP3, exp);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    total = 0;
    passed = 0;
    reset = 1'b1;
    bus.OP1 = '0;
    bus.OP2 = '0;
    bus.ALUOP = '0;
    bus.CSR_ALU_IN = 3'b000;
    step();
    step();
    reset = 1'b0;
    chk("rst_out", 32'(bus.CSR_ALU_OUT), 32'h1);
    chk("rst_op3", bus.OP3, 32'h0);

    run_op(32'd5, 32'd7, 4'd0, 0, "add");

    bus.OP1 = 32'd11;
    bus.CSR_ALU_IN = 3'b010;
    step();
    bus.OP2 = 32'd22;
    bus.ALUOP = 4'd0;
    bus.CSR_ALU_IN = 3'b100;
    step();
    bus.CSR_ALU_IN = 3'b000;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_out", 32'(bus.CSR_ALU_OUT), 32'h1);
    chk("abort_op3", bus.OP3, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_idle", 32'(bus.CSR_ALU_OUT), 32'h1);
    end

    run_op(32'h8000_0000, 32'd4, 4'd7, 0, "sra");
    run_op(32'h8000_0000, 32'd4, 4'd6, 0, "srl");
    run_op(32'h8000_0000, 32'd1, 4'd8, 0, "slt");
    run_op(32'h0000_0001, 32'h8000_0000, 4'd9, 0, "sltu");

    bus.OP2 = 32'd9;
    bus.CSR_ALU_IN = 3'b100;
    step();
    bus.CSR_ALU_IN = 3'b000;
    chk("early_op2", 32'(bus.CSR_ALU_OUT), 32'h1);
    run_op(32'd3, 32'd2, 4'd1, 0, "order");

    bus.OP1 = 32'd40;
    bus.OP2 = 32'd99;
    bus.CSR_ALU_IN = 3'b110;
    step();
    bus.CSR_ALU_IN = 3'b000;
    chk("both_strobe", 32'(bus.CSR_ALU_OUT), 32'h2);
    bus.OP1 = 32'd1;
    bus.CSR_ALU_IN = 3'b010;
    step();
    chk("re_op1", 32'(bus.CSR_ALU_OUT), 32'h2);
    bus.OP2 = 32'd2;
    bus.ALUOP = 4'd1;
    bus.CSR_ALU_IN = 3'b100;
    step();
    bus.CSR_ALU_IN = 3'b000;
    for (int i = 0; i < L; i++) step();
    chk("both_res", bus.OP3, 32'd38);
    bus.CSR_ALU_IN = 3'b001;
    step();
    bus.CSR_ALU_IN = 3'b000;
    step();

    run_op(32'hDEAD_BEEF, 32'h1234_5678, 4'd4, 10, "hold");
    run_op(32'hFFFF_FFFF, 32'd2, 4'd13, 0, "undef");

`ifdef ALU_MULDIV_EN
    run_op(32'hFFFF_FFFF, 32'd2, 4'd11, 0, "mulhu");
    run_op(32'hFFFF_FFFF, 32'd0, 4'd12, 0, "divu0");
    run_op(32'd1234, 32'd5678, 4'd10, 0, "mul");
`endif

    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rop = 4'($urandom_range(0, 15));
      run_op(ra, rb, rop, int'($urandom_range(0, 2)), "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_csr_responder.md
Name: alu_csr_responder

Overview:
Responder end of the FU-stage ALU CSR handshake: the external ALU that FU_STAGE drives. It advertises operand-port readiness, captures OP1 then OP2/ALUOP on the initiator's stable strobes, and computes over a parameterised latency. It presents OP3 with result-valid and holds it under the initiator's protect bit until released. It is a drop-in, cycle-accurate model for FU-stage integration and verification.

Parameters:
DBITS, 32, operand/result width
OPBITS, 4, ALUOP width
LATENCY, 3, cycles from the OP2-capture edge to result-valid assertion; legal range 1..15

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
OP1  in  DBITS  operand 1, sampled while CSR_ALU_IN[1]=1 in S_OP1
OP2  in  DBITS  operand 2, sampled while CSR_ALU_IN[2]=1 in S_OP2
ALUOP  in  OPBITS  operation, sampled with OP2
CSR_ALU_IN  in  3  [0] result protect (level), [1] OP1 stable (strobe), [2] OP2 stable (strobe)
OP3  out  DBITS  result register
CSR_ALU_OUT  out  3  [0] OP1 port ready, [1] OP2 port ready, [2] result valid

Behaviour:
- Reset (also mid-operation): state S_OP1; OP3=0; CSR_ALU_OUT=3'b001 from the first cycle after reset; latched operands, op and counter cleared. Any in-flight computation is discarded.
- All outputs are registered, and CSR_ALU_OUT is decoded one-hot from state: S_OP1->001, S_OP2->010, S_CALC->000, S_RES->100, S_HOLD->100.
- S_OP1: when IN[1]=1 at an edge, latch OP1 and go to S_OP2. IN[2] and IN[0] are ignored here, including when IN[1] and IN[2] are high in the same cycle.
- S_OP2: when IN[2]=1, latch OP2 and ALUOP, load counter=LATENCY, and go to S_CALC. A repeated IN[1] is ignored, and OP1 is not re-latched.
- S_CALC: decrement the counter each cycle. On the cycle the counter equals 1, write OP3 with the result and go to S_RES. CSR_ALU_OUT[2] therefore rises exactly LATENCY edges after the OP2-capture edge. All strobes are ignored.
- S_RES: when IN[0]=1, go to S_HOLD. Strobes are ignored.
- S_HOLD: when IN[0]=0, go to S_OP1. OUT[2] drops and OUT[0] rises on the same edge.
- OP3 holds its value in every state except the S_CALC write; it is never cleared except by reset.
- Ops use unsigned modulo-2^DBITS arithmetic unless stated:
  - 0 ADD; 1 SUB (OP1-OP2)
  - 2 AND; 3 OR; 4 XOR
  - 5 SLL; 6 SRL; 7 SRA (shift amount OP2[4:0])
  - 8 SLT signed (result 1/0); 9 SLTU (result 1/0)
  - 10..15 give result 0 (see optional feature).
- Back-to-back: a new IN[1] is accepted in the first cycle S_OP1 is re-entered.

Optional Feature:
ALU_MULDIV_EN. Defined: op 10 MUL gives low DBITS of OP1*OP2; op 11 MULHU gives the high DBITS of the unsigned product; op 12 DIVU gives OP1/OP2, with divide-by-zero returning all ones. These ops use an effective latency of max(LATENCY,4). Undefined: ops 10..15 give 0 with normal latency. Interface and timing are otherwise identical.

Test Plan:
- Reset asserted mid-S_CALC, then released -> next cycle CSR_ALU_OUT=001, OP3=0, no result-valid ever appears for the aborted op.
- OP1=5 (IN[1] pulse), then OP2=7, ALUOP=0 (IN[2] pulse), LATENCY=3 -> OUT[2]=1 exactly 3 edges after the OP2 capture, OP3=12; raise IN[0], then drop it -> OUT=001 one edge after the drop, OP3 still 12.
- OP1=0x80000000, OP2=4, ALUOP=7 -> OP3=0xF8000000; ALUOP=6 -> 0x08000000; ALUOP=8 with OP2=1 -> OP3=1.
- Ordering: IN[2] pulsed in S_OP1 with OP2=9, then IN[1] with OP1=3, then IN[2] with OP2=2, ALUOP=1 -> the early strobe is ignored and OP3=1. IN[1] and IN[2] asserted together in S_OP1 -> only OP1 latched, state S_OP2.
- Hold: IN[0] kept high for 10 cycles after result-valid -> OUT stays 100 and OP3 is stable; IN[1] pulses during the hold have no effect.
- With ALU_MULDIV_EN: OP1=0xFFFFFFFF, OP2=2, op 11 -> OP3=1; op 12 with OP2=0 -> OP3=0xFFFFFFFF; with LATENCY=1, result-valid appears 4 edges after capture.
